// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
//   Request/response handshake bundle between the MEM stage and the
//   load/store unit.
//   master : request producer / response consumer (MEM stage, testbench)
//   slave  : the load/store unit itself
//   Request : req_valid, req_ready, req_we, req_addr, req_size,
//             req_unsigned, req_wdata
//   Response: resp_valid, resp_ready, resp_rdata, resp_err
interface mem_access_unit_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [63:0]     req_addr;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Handshaked load/store unit in front of simulated physical memory.
//   A request is captured in IDLE, held for LATENCY edges, then a single
//   memory access is issued and the (extended) result is presented until
//   the consumer takes it. Misaligned requests never touch memory and
//   return resp_err with zero data after the same latency.
//
//   Parameters
//     XLEN     data width (64 only, 8 byte lanes)
//     LATENCY  edges from request accept to resp_valid (>= 1)
//   Ports
//     clk, rst_n     clock (posedge) and async active-low reset
//     bus            request/response handshake (slave side)
//     pmem_req_o     one-cycle memory access strobe, once per good request
//     pmem_we_o      1 = masked write, 0 = read
//     pmem_addr_o    dword-aligned memory address
//     pmem_wdata_o   store data shifted into its byte lanes
//     pmem_wmask_o   byte-lane write enables
//     pmem_rdata_i   dword read data for pmem_addr_o (combinational)
//
//   state  | meaning
//   -------+------------------------------------------------------
//   IDLE   | ready for a request
//   WAIT   | request captured, counting down latency; access at 0
//   RESP   | response presented, waiting for resp_ready
module mem_access_unit #(
  parameter int XLEN    = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  bus,
  output logic              pmem_req_o,
  output logic              pmem_we_o,
  output logic [63:0]       pmem_addr_o,
  output logic [XLEN-1:0]   pmem_wdata_o,
  output logic [XLEN/8-1:0] pmem_wmask_o,
  input  logic [XLEN-1:0]   pmem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [63:0]     addr_q, addr_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;

  logic            misaligned;
  logic [7:0]      lane_mask;
  logic [5:0]      bit_off;
  logic [XLEN-1:0] ld_shift;
  logic [XLEN-1:0] ld_ext;
  logic            access_now;

  assign bit_off    = {addr_q[2:0], 3'b000};
  assign access_now = (state_q == S_WAIT) && (cnt_q == '0);

  // Alignment check and lane mask of the captured request.
  always_comb begin
    misaligned = 1'b0;
    lane_mask  = 8'h00;
    case (size_q)
      2'd0: begin
        misaligned = 1'b0;
        lane_mask  = 8'h01 << addr_q[2:0];
      end
      2'd1: begin
        misaligned = addr_q[0];
        lane_mask  = 8'h03 << addr_q[2:0];
      end
      2'd2: begin
        misaligned = |addr_q[1:0];
        lane_mask  = 8'h0F << addr_q[2:0];
      end
      default: begin
        misaligned = |addr_q[2:0];
        lane_mask  = 8'hFF;
      end
    endcase
  end

  // Bring the addressed bytes down to bit 0, then extend to full width.
  always_comb begin
    ld_shift = pmem_rdata_i >> bit_off;
    ld_ext   = ld_shift;
    case (size_q)
      2'd0: ld_ext = {{(XLEN-8){~uns_q & ld_shift[7]}}, ld_shift[7:0]};
      2'd1: ld_ext = {{(XLEN-16){~uns_q & ld_shift[15]}}, ld_shift[15:0]};
      2'd2: ld_ext = {{(XLEN-32){~uns_q & ld_shift[31]}}, ld_shift[31:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          wdata_d = bus.req_wdata;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          // The memory access happens on this edge; capture its outcome.
          state_d = S_RESP;
          err_d   = misaligned;
          rdata_d = (misaligned || we_q) ? '0 : ld_ext;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Handshake flags are registered copies of the next state's decode.
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
  end

  // Output logic
  always_comb begin
    bus.req_ready  = req_ready_q;
    bus.resp_valid = resp_valid_q;
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
    pmem_req_o     = access_now && !misaligned;
    pmem_we_o      = we_q;
    pmem_addr_o    = {addr_q[63:3], 3'b000};
    pmem_wdata_o   = wdata_q << bit_off;
    pmem_wmask_o   = lane_mask;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Two instances (LATENCY=2 and LATENCY=1), each with its own byte-masked
//   dword memory. A transaction-level model predicts handshake timing,
//   memory strobes and response data; it is compared every cycle.
module tb_mem_access_unit;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam int          LAT0 = 2;
  localparam int          LAT1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.XLEN(64)) bus0 ();
  mem_access_unit_if #(.XLEN(64)) bus1 ();

  // Driven inputs / observed outputs, indexed by DUT
  logic        i_v[2], i_we[2], i_uns[2], i_rr[2];
  logic [63:0] i_addr[2], i_wdata[2];
  logic [1:0]  i_size[2];
  logic        o_rr[2], o_rv[2], o_err[2];
  logic [63:0] o_rdata[2];
  logic        p_req[2], p_we[2];
  logic [63:0] p_addr[2], p_wdata[2];
  logic [7:0]  p_mask[2];

  logic        pm0_req, pm0_we, pm1_req, pm1_we;
  logic [63:0] pm0_addr, pm0_wdata, pm0_rdata, pm1_addr, pm1_wdata, pm1_rdata;
  logic [7:0]  pm0_mask, pm1_mask;

  mem_access_unit #(.XLEN(64), .LATENCY(LAT0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .pmem_req_o(pm0_req), .pmem_we_o(pm0_we), .pmem_addr_o(pm0_addr),
    .pmem_wdata_o(pm0_wdata), .pmem_wmask_o(pm0_mask), .pmem_rdata_i(pm0_rdata)
  );

  mem_access_unit #(.XLEN(64), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .pmem_req_o(pm1_req), .pmem_we_o(pm1_we), .pmem_addr_o(pm1_addr),
    .pmem_wdata_o(pm1_wdata), .pmem_wmask_o(pm1_mask), .pmem_rdata_i(pm1_rdata)
  );

  assign bus0.req_valid    = i_v[0];
  assign bus0.req_we       = i_we[0];
  assign bus0.req_addr     = i_addr[0];
  assign bus0.req_size     = i_size[0];
  assign bus0.req_unsigned = i_uns[0];
  assign bus0.req_wdata    = i_wdata[0];
  assign bus0.resp_ready   = i_rr[0];
  assign bus1.req_valid    = i_v[1];
  assign bus1.req_we       = i_we[1];
  assign bus1.req_addr     = i_addr[1];
  assign bus1.req_size     = i_size[1];
  assign bus1.req_unsigned = i_uns[1];
  assign bus1.req_wdata    = i_wdata[1];
  assign bus1.resp_ready   = i_rr[1];

  assign o_rr[0] = bus0.req_ready;   assign o_rr[1] = bus1.req_ready;
  assign o_rv[0] = bus0.resp_valid;  assign o_rv[1] = bus1.resp_valid;
  assign o_err[0] = bus0.resp_err;   assign o_err[1] = bus1.resp_err;
  assign o_rdata[0] = bus0.resp_rdata; assign o_rdata[1] = bus1.resp_rdata;

  assign p_req[0] = pm0_req;     assign p_req[1] = pm1_req;
  assign p_we[0] = pm0_we;       assign p_we[1] = pm1_we;
  assign p_addr[0] = pm0_addr;   assign p_addr[1] = pm1_addr;
  assign p_wdata[0] = pm0_wdata; assign p_wdata[1] = pm1_wdata;
  assign p_mask[0] = pm0_mask;   assign p_mask[1] = pm1_mask;

  // Simulated physical memory: 32 dwords above BASE per DUT
  logic [63:0] hwm [2][32];
  logic [63:0] init_v [2][32];
  logic        load_mem = 1'b1;
  logic [63:0] last_waddr[2], last_wdata[2];
  logic [7:0]  last_wmask[2];

  assign pm0_rdata = hwm[0][pm0_addr[7:3]];
  assign pm1_rdata = hwm[1][pm1_addr[7:3]];

  function automatic logic [63:0] merge_bytes(logic [63:0] old, logic [63:0] nw, logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (load_mem) begin
        for (int i = 0; i < 32; i++) hwm[d][i] <= init_v[d][i];
      end else if (p_req[d] && p_we[d]) begin
        hwm[d][p_addr[d][7:3]] <= merge_bytes(hwm[d][p_addr[d][7:3]], p_wdata[d], p_mask[d]);
        last_waddr[d] <= p_addr[d];
        last_wdata[d] <= p_wdata[d];
        last_wmask[d] <= p_mask[d];
      end
    end
  end

  // ---------------- reference model ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  longint      cyc = 0;
  bit          busy[2];
  longint      due[2];
  bit          e_err[2], e_call[2], e_we[2];
  logic [63:0] e_rdata[2], e_addr[2], e_wdata[2];
  logic [7:0]  e_mask[2];
  logic [4:0]  e_idx[2];
  int          calls[2], e_calls[2];
  logic [63:0] refm [2][32];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_accept(int d);
    int          nb, off;
    logic [63:0] v, lim;
    nb  = 1 << i_size[d];
    off = int'(i_addr[d][2:0]);
    busy[d]    = 1'b1;
    due[d]     = cyc + 1 + lat_of(d);
    e_err[d]   = (i_addr[d] & 64'(nb - 1)) != 64'd0;
    e_call[d]  = !e_err[d];
    e_we[d]    = i_we[d];
    e_addr[d]  = i_addr[d] - 64'(off);
    e_idx[d]   = i_addr[d][7:3];
    e_wdata[d] = i_wdata[d] << (8 * off);
    e_mask[d]  = 8'(((1 << nb) - 1) << off);
    e_rdata[d] = 64'd0;
    if (e_call[d] && !i_we[d]) begin
      v = refm[d][e_idx[d]] >> (8 * off);
      if (nb < 8) begin
        lim = (64'd1 << (8 * nb)) - 64'd1;
        v = v & lim;
        if (!i_uns[d] && v[8*nb-1]) v = v | ~lim;
      end
      e_rdata[d] = v;
    end
  endtask

  task automatic check_dut(int d);
    bit exp_rv, exp_call;
    exp_rv   = busy[d] && (cyc >= due[d]);
    exp_call = busy[d] && e_call[d] && (cyc == due[d] - 1);
    chk($sformatf("dut%0d req_ready", d), 64'(o_rr[d]), 64'(!busy[d]));
    chk($sformatf("dut%0d resp_valid", d), 64'(o_rv[d]), 64'(exp_rv));
    if (exp_rv) begin
      chk($sformatf("dut%0d resp_rdata", d), o_rdata[d], e_rdata[d]);
      chk($sformatf("dut%0d resp_err", d), 64'(o_err[d]), 64'(e_err[d]));
    end
    chk($sformatf("dut%0d pmem_req", d), 64'(p_req[d]), 64'(exp_call));
    if (p_req[d]) calls[d]++;
    if (exp_call) begin
      e_calls[d]++;
      chk($sformatf("dut%0d pmem_we", d), 64'(p_we[d]), 64'(e_we[d]));
      chk($sformatf("dut%0d pmem_addr", d), p_addr[d], e_addr[d]);
      if (e_we[d]) begin
        chk($sformatf("dut%0d pmem_wdata", d), p_wdata[d], e_wdata[d]);
        chk($sformatf("dut%0d pmem_mask", d), 64'(p_mask[d]), 64'(e_mask[d]));
        refm[d][e_idx[d]] = merge_bytes(refm[d][e_idx[d]], e_wdata[d], e_mask[d]);
      end
    end
    if (!busy[d]) begin
      if (i_v[d]) model_accept(d);
    end else if (exp_rv && i_rr[d]) begin
      busy[d] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_dut(0);
      check_dut(1);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic txn(int d, bit we, logic [63:0] addr, logic [1:0] size, bit uns,
                     logic [63:0] wdata, int hold,
                     output logic [63:0] rdata, output bit err, output int lat_obs);
    int     n;
    longint acc;
    @(posedge clk); #1;
    i_v[d] = 1'b1; i_we[d] = we; i_addr[d] = addr; i_size[d] = size;
    i_uns[d] = uns; i_wdata[d] = wdata; i_rr[d] = 1'b0;
    n = 0;
    while (!o_rr[d] && n < 20) begin @(posedge clk); #1; n++; end
    chk($sformatf("dut%0d ready for txn", d), 64'(o_rr[d]), 64'd1);
    acc = cyc + 1;
    @(posedge clk); #1;
    i_v[d] = 1'b0;
    i_rr[d] = (hold == 0);
    n = 0;
    while (!o_rv[d] && n < 20) begin @(posedge clk); #1; n++; end
    chk($sformatf("dut%0d response seen", d), 64'(o_rv[d]), 64'd1);
    lat_obs = int'(cyc - acc);
    for (int k = 0; k < hold; k++) begin
      i_v[d] = 1'($urandom_range(0, 1));
      i_addr[d] = BASE + 64'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    i_v[d] = 1'b0;
    rdata = o_rdata[d];
    err = o_err[d];
    i_rr[d] = 1'b1;
    @(posedge clk); #1;
    i_rr[d] = 1'b0;
  endtask

  task automatic chk_reset_values(string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s dut%0d req_ready", tag, d), 64'(o_rr[d]), 64'd1);
      chk($sformatf("%s dut%0d resp_valid", tag, d), 64'(o_rv[d]), 64'd0);
      chk($sformatf("%s dut%0d resp_rdata", tag, d), o_rdata[d], 64'd0);
      chk($sformatf("%s dut%0d resp_err", tag, d), 64'(o_err[d]), 64'd0);
      chk($sformatf("%s dut%0d pmem_req", tag, d), 64'(p_req[d]), 64'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] rd, first;
    bit          er, got;
    int          lo, c0, nacc;

    for (int d = 0; d < 2; d++) begin
      i_v[d] = 1'b0; i_we[d] = 1'b0; i_uns[d] = 1'b0; i_rr[d] = 1'b0;
      i_addr[d] = BASE; i_wdata[d] = 64'd0; i_size[d] = 2'd0;
      busy[d] = 1'b0; calls[d] = 0; e_calls[d] = 0;
      for (int i = 0; i < 32; i++) begin
        init_v[d][i] = {$urandom, $urandom};
        refm[d][i] = init_v[d][i];
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("reset");
    load_mem = 1'b0;
    rst_n = 1'b1;

    // 1: aligned dword store
    c0 = calls[0];
    txn(0, 1'b1, BASE, 2'd3, 1'b0, 64'h1122334455667788, 0, rd, er, lo);
    chk("t1 latency", 64'(lo), 64'd2);
    chk("t1 rdata", rd, 64'd0);
    chk("t1 err", 64'(er), 64'd0);
    chk("t1 calls", 64'(calls[0] - c0), 64'd1);
    chk("t1 wmask", 64'(last_wmask[0]), 64'hFF);
    chk("t1 mem", hwm[0][0], 64'h1122334455667788);

    // 2: byte store then signed / unsigned byte loads
    txn(0, 1'b1, BASE + 64'd5, 2'd0, 1'b0, 64'hAB, 0, rd, er, lo);
    chk("t2 waddr", last_waddr[0], BASE);
    chk("t2 wdata", last_wdata[0], 64'h0000AB0000000000);
    chk("t2 wmask", 64'(last_wmask[0]), 64'h20);
    chk("t2 mem", hwm[0][0], 64'h1122AB4455667788);
    txn(0, 1'b0, BASE + 64'd5, 2'd0, 1'b0, 64'd0, 0, rd, er, lo);
    chk("t2 lb signed", rd, 64'hFFFFFFFFFFFFFFAB);
    txn(0, 1'b0, BASE + 64'd5, 2'd0, 1'b1, 64'd0, 0, rd, er, lo);
    chk("t2 lb unsigned", rd, 64'h00000000000000AB);

    // 3: misaligned half load
    c0 = calls[0];
    txn(0, 1'b0, BASE + 64'd3, 2'd1, 1'b0, 64'd0, 0, rd, er, lo);
    chk("t3 err", 64'(er), 64'd1);
    chk("t3 rdata", rd, 64'd0);
    chk("t3 calls", 64'(calls[0] - c0), 64'd0);
    chk("t3 latency", 64'(lo), 64'd2);

    // 4: response held off for 5 cycles with stray request pulses
    c0 = calls[0];
    txn(0, 1'b0, BASE, 2'd3, 1'b0, 64'd0, 5, rd, er, lo);
    chk("t4 rdata", rd, 64'h1122AB4455667788);
    chk("t4 calls", 64'(calls[0] - c0), 64'd1);

    // 5: reset while a store is still waiting
    c0 = calls[0];
    @(posedge clk); #1;
    i_v[0] = 1'b1; i_we[0] = 1'b1; i_addr[0] = BASE + 64'd16; i_size[0] = 2'd3;
    i_wdata[0] = 64'hDEADBEEFCAFEF00D;
    @(posedge clk); #1;
    i_v[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    busy[0] = 1'b0;
    busy[1] = 1'b0;
    #1;
    chk_reset_values("t5 async reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t5 calls", 64'(calls[0] - c0), 64'd0);
    chk("t5 mem untouched", hwm[0][2], init_v[0][2]);
    txn(0, 1'b0, BASE + 64'd16, 2'd3, 1'b0, 64'd0, 0, rd, er, lo);
    chk("t5 reload", rd, init_v[0][2]);
    chk("t5 latency", 64'(lo), 64'd2);

    // 6: LATENCY=1 back-to-back signed word loads
    txn(1, 1'b1, BASE, 2'd3, 1'b0, 64'h8000000012345678, 0, rd, er, lo);
    chk("t6 store latency", 64'(lo), 64'd1);
    @(posedge clk); #1;
    i_v[1] = 1'b1; i_we[1] = 1'b0; i_addr[1] = BASE + 64'd4; i_size[1] = 2'd2;
    i_uns[1] = 1'b0; i_rr[1] = 1'b1;
    nacc = 0; got = 1'b0; first = 64'd0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (o_rr[1]) nacc++;
      if (o_rv[1] && !got) begin first = o_rdata[1]; got = 1'b1; end
    end
    chk("t6 accepts in 30 edges", 64'(nacc), 64'd10);
    chk("t6 lw signed", first, 64'hFFFFFFFF80000000);
    @(posedge clk); #1;
    i_v[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    i_rr[1] = 1'b0;

    // random traffic on both instances
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        i_v[d]     = ($urandom_range(0, 2) != 0);
        i_we[d]    = 1'($urandom_range(0, 1));
        i_uns[d]   = 1'($urandom_range(0, 1));
        i_size[d]  = 2'($urandom_range(0, 3));
        i_addr[d]  = BASE + 64'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) i_addr[d] &= ~64'((1 << i_size[d]) - 1);
        i_wdata[d] = {$urandom, $urandom};
        i_rr[d]    = ($urandom_range(0, 3) != 0);
      end
    end

    for (int d = 0; d < 2; d++) begin
      i_v[d] = 1'b0;
      i_rr[d] = 1'b1;
    end
    repeat (8) @(posedge clk);
    #1;

    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d total pmem calls", d), 64'(calls[d]), 64'(e_calls[d]));
      for (int i = 0; i < 32; i++)
        chk($sformatf("dut%0d final mem[%0d]", d, i), hwm[d][i], refm[d][i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
